// File: rtl/instr_encoder_pkg.sv
// Shared encoding definitions for the instruction encoder/loader:
// opcodes, request kinds, instruction field positions and immediate limits.
package instr_encoder_pkg;

   typedef enum logic [3:0] {
      KIND_R    = 4'd0,
      KIND_LW   = 4'd1,
      KIND_SW   = 4'd2,
      KIND_J    = 4'd3,
      KIND_BEQ  = 4'd4,
      KIND_BNE  = 4'd5,
      KIND_ADDI = 4'd6,
      KIND_JAL  = 4'd7,
      KIND_JR   = 4'd8
   } kind_e;

   localparam logic [7:0] OP_R    = 8'h18;
   localparam logic [7:0] OP_LW   = 8'h19;
   localparam logic [7:0] OP_SW   = 8'h1A;
   localparam logic [7:0] OP_J    = 8'h1B;
   localparam logic [7:0] OP_BEQ  = 8'h1C;
   localparam logic [7:0] OP_BNE  = 8'h1D;
   localparam logic [7:0] OP_ADDI = 8'h1E;
   localparam logic [7:0] OP_JAL  = 8'h03;
   localparam logic [7:0] OP_JR   = 8'h00;
   localparam logic [3:0] FUNCT_JR = 4'b1000;

   localparam int OP_MSB     = 31;
   localparam int OP_LSB     = 24;
   localparam int RS_MSB     = 23;
   localparam int RS_LSB     = 19;
   localparam int RT_MSB     = 18;
   localparam int RT_LSB     = 14;
   localparam int RD_MSB     = 13;
   localparam int RD_LSB     = 9;
   localparam int FUNCT_MSB  = 3;
   localparam int IMM_MSB    = 13;
   localparam int TARGET_MSB = 23;

   localparam logic signed [15:0] IMM_MIN = -16'sd8192;
   localparam logic signed [15:0] IMM_MAX = 16'sd8191;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words; flush empties it while
// still allowing a same-cycle push to land as the first entry.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      used;
   logic             do_push;
   logic             do_pop;

   assign full    = (used == (AW+1)'(DEPTH));
   assign empty   = (used == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         used   <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= AW'(push);
         used   <= (AW+1)'(push);
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   used <= used + (AW+1)'(1);
            2'b01:   used <= used - (AW+1)'(1);
            default: used <= used;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed while counted in used.
   always_ff @(posedge clk) begin
      if (flush && push)
         mem[0] <= din;
      else if (!flush && do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into 32-bit words, buffers them and
// streams them into instruction memory at consecutive addresses.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [3:0]        req_funct,
   input  logic [15:0]       req_imm,
   input  logic [23:0]       req_target,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic [15:0]       count,
   output logic              err,
   input  logic              err_clr
);

   logic [31:0] enc_word;
   logic        enc_legal;
   logic        imm_ok;
   logic        accept;
   logic        push;
   logic        pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;

   assign imm_ok = ($signed(req_imm) >= IMM_MIN) && ($signed(req_imm) <= IMM_MAX);

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (kind_e'(req_kind))
         KIND_R: begin
            enc_word[OP_MSB:OP_LSB]  = OP_R;
            enc_word[RS_MSB:RS_LSB]  = req_rs;
            enc_word[RT_MSB:RT_LSB]  = req_rt;
            enc_word[RD_MSB:RD_LSB]  = req_rd;
            enc_word[FUNCT_MSB:0]    = req_funct;
         end
         KIND_LW, KIND_SW, KIND_BEQ, KIND_BNE, KIND_ADDI: begin
            case (kind_e'(req_kind))
               KIND_LW:  enc_word[OP_MSB:OP_LSB] = OP_LW;
               KIND_SW:  enc_word[OP_MSB:OP_LSB] = OP_SW;
               KIND_BEQ: enc_word[OP_MSB:OP_LSB] = OP_BEQ;
               KIND_BNE: enc_word[OP_MSB:OP_LSB] = OP_BNE;
               default:  enc_word[OP_MSB:OP_LSB] = OP_ADDI;
            endcase
            enc_word[RS_MSB:RS_LSB] = req_rs;
            enc_word[RT_MSB:RT_LSB] = req_rt;
            enc_word[IMM_MSB:0]     = req_imm[IMM_MSB:0];
            enc_legal               = imm_ok;
         end
         KIND_J: begin
            enc_word[OP_MSB:OP_LSB] = OP_J;
            enc_word[TARGET_MSB:0]  = req_target;
         end
         KIND_JAL: begin
            enc_word[OP_MSB:OP_LSB] = OP_JAL;
            enc_word[TARGET_MSB:0]  = req_target;
         end
         KIND_JR: begin
            enc_word[OP_MSB:OP_LSB] = OP_JR;
            enc_word[RS_MSB:RS_LSB] = req_rs;
            enc_word[FUNCT_MSB:0]   = FUNCT_JR;
         end
         default: enc_legal = 1'b0;
      endcase
   end

   // A write handshake coinciding with start is swallowed by the flush.
   assign req_ready = !fifo_full;
   assign accept    = req_valid && req_ready;
   assign push      = accept && enc_legal;
   assign pop       = wr_en && wr_ready && !start;
   assign wr_en     = !fifo_empty;
   assign busy      = !fifo_empty;
   assign wr_data   = fifo_empty ? 32'h0 : fifo_head;

   instr_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (start),
      .push  (push),
      .pop   (pop),
      .din   (enc_word),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
         count   <= '0;
      end else if (start) begin
         wr_addr <= base_addr;
         count   <= '0;
      end else if (pop) begin
         wr_addr <= wr_addr + ADDR_W'(1);
         if (count != 16'hFFFF) count <= count + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (accept && !enc_legal)
         err <= 1'b1;
      else if (err_clr)
         err <= 1'b0;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed vectors, hand sequences for
// backpressure/wrap/reset, and randomized traffic against a queue model.
module tb_instr_encoder;

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  funct;
      logic [15:0] imm;
      logic [23:0] target;
   } req_t;

   typedef struct {
      req_t        r;
      logic [31:0] exp_word;
      bit          exp_legal;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  base_addr;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_kind;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [3:0]  req_funct;
   logic [15:0] req_imm;
   logic [23:0] req_target;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        busy;
   logic [15:0] count;
   logic        err;
   logic        err_clr;

   int checks;
   int failures;

   logic [31:0] mq[$];
   int          m_addr;
   int          m_count;
   bit          m_err;

   vec_t vecs[13];

   instr_encoder #(.ADDR_W(10), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_kind   (req_kind),
      .req_rs     (req_rs),
      .req_rt     (req_rt),
      .req_rd     (req_rd),
      .req_funct  (req_funct),
      .req_imm    (req_imm),
      .req_target (req_target),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .busy       (busy),
      .count      (count),
      .err        (err),
      .err_clr    (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic req_t mkReq(int kind, int rs, int rt, int rd, int funct, int imm, int target);
      req_t r;
      r.kind   = 4'(kind);
      r.rs     = 5'(rs);
      r.rt     = 5'(rt);
      r.rd     = 5'(rd);
      r.funct  = 4'(funct);
      r.imm    = 16'(imm);
      r.target = 24'(target);
      return r;
   endfunction

   // Reference encoding straight from the word-format rules, using arithmetic.
   function automatic logic [31:0] modelEncode(req_t r, output bit legal);
      int simm;
      int ifield;
      int opc;
      simm   = int'($signed(r.imm));
      ifield = (simm + 65536) % 16384;
      legal  = 1'b1;
      opc    = 0;
      case (int'(r.kind))
         0: return 32'('h18 * 2**24 + int'(r.rs) * 2**19 + int'(r.rt) * 2**14
                        + int'(r.rd) * 2**9 + int'(r.funct));
         1, 2, 4, 5, 6: begin
            case (int'(r.kind))
               1: opc = 'h19;
               2: opc = 'h1A;
               4: opc = 'h1C;
               5: opc = 'h1D;
               default: opc = 'h1E;
            endcase
            legal = (simm >= -8192) && (simm <= 8191);
            return 32'(opc * 2**24 + int'(r.rs) * 2**19 + int'(r.rt) * 2**14 + ifield);
         end
         3: return 32'('h1B * 2**24 + int'(r.target));
         7: return 32'('h03 * 2**24 + int'(r.target));
         8: return 32'(int'(r.rs) * 2**19 + 8);
         default: begin
            legal = 1'b0;
            return 32'h0;
         end
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareModel();
      checkOutput("req_ready", 32'(req_ready), 32'(mq.size() < 4));
      checkOutput("busy",      32'(busy),      32'(mq.size() != 0));
      checkOutput("wr_en",     32'(wr_en),     32'(mq.size() != 0));
      checkOutput("wr_data",   wr_data,        (mq.size() != 0) ? mq[0] : 32'h0);
      checkOutput("wr_addr",   32'(wr_addr),   32'(m_addr));
      checkOutput("count",     32'(count),     32'(m_count));
      checkOutput("err",       32'(err),       32'(m_err));
   endtask

   task automatic modelReset();
      mq.delete();
      m_addr  = 0;
      m_count = 0;
      m_err   = 1'b0;
   endtask

   // Drives one cycle of inputs, checks outputs against the model, then clocks.
   task automatic applyStimulus(input logic st, input logic [9:0] base, input logic valid,
                                input req_t r, input logic wrdy, input logic clr);
      bit          ready;
      bit          legal;
      bit          pop;
      logic [31:0] word;
      start      = st;
      base_addr  = base;
      req_valid  = valid;
      req_kind   = r.kind;
      req_rs     = r.rs;
      req_rt     = r.rt;
      req_rd     = r.rd;
      req_funct  = r.funct;
      req_imm    = r.imm;
      req_target = r.target;
      wr_ready   = wrdy;
      err_clr    = clr;
      compareModel();
      ready = (mq.size() < 4);
      word  = modelEncode(r, legal);
      pop   = (mq.size() != 0) && wrdy && !st;
      if (st) begin
         mq.delete();
         m_addr  = int'(base);
         m_count = 0;
      end else if (pop) begin
         void'(mq.pop_front());
         m_addr = (m_addr + 1) % 1024;
         if (m_count < 65535) m_count++;
      end
      if (valid && ready && legal) mq.push_back(word);
      if (valid && ready && !legal) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      @(posedge clk);
      #1;
   endtask

   req_t idle;
   req_t rr;

   initial begin
      checks   = 0;
      failures = 0;
      idle     = mkReq(0, 0, 0, 0, 0, 0, 0);
      vecs[0]  = '{mkReq(6, 1, 2, 0, 0, 5, 0),        32'h1E088005, 1'b1};
      vecs[1]  = '{mkReq(1, 0, 3, 0, 0, -4, 0),       32'h1900FFFC, 1'b1};
      vecs[2]  = '{mkReq(0, 1, 2, 3, 2, 0, 0),        32'h18088602, 1'b1};
      vecs[3]  = '{mkReq(8, 31, 0, 0, 0, 0, 0),       32'h00F80008, 1'b1};
      vecs[4]  = '{mkReq(2, 2, 5, 0, 0, 8191, 0),     32'h1A115FFF, 1'b1};
      vecs[5]  = '{mkReq(4, 4, 4, 0, 0, -8192, 0),    32'h1C212000, 1'b1};
      vecs[6]  = '{mkReq(5, 0, 0, 0, 0, -1, 0),       32'h1D003FFF, 1'b1};
      vecs[7]  = '{mkReq(3, 0, 0, 0, 0, 0, 'hABCDEF), 32'h1BABCDEF, 1'b1};
      vecs[8]  = '{mkReq(7, 0, 0, 0, 0, 0, 'h000100), 32'h03000100, 1'b1};
      vecs[9]  = '{mkReq(12, 1, 1, 1, 1, 0, 0),       32'h0,        1'b0};
      vecs[10] = '{mkReq(6, 1, 2, 0, 0, 9000, 0),     32'h0,        1'b0};
      vecs[11] = '{mkReq(6, 1, 2, 0, 0, 8192, 0),     32'h0,        1'b0};
      vecs[12] = '{mkReq(1, 1, 2, 0, 0, -8193, 0),    32'h0,        1'b0};

      rst_n = 1'b0;
      start = 1'b0; base_addr = '0; req_valid = 1'b0; wr_ready = 1'b0; err_clr = 1'b0;
      req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_funct = '0;
      req_imm = '0; req_target = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      compareModel();
      rst_n = 1'b1;
      applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b0, 1'b0);

      // Fixed vectors: one request, then one drain cycle checking the word.
      applyStimulus(1'b1, 10'h010, 1'b0, idle, 1'b1, 1'b0);
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b0, 10'h0, 1'b1, vecs[i].r, 1'b1, 1'b0);
         if (vecs[i].exp_legal) begin
            checkOutput("vec_wr_en", 32'(wr_en), 32'h1);
            checkOutput("vec_word", wr_data, vecs[i].exp_word);
         end else begin
            checkOutput("vec_discard", 32'(wr_en), 32'h0);
            checkOutput("vec_err", 32'(err), 32'h1);
         end
         if (i == 0) checkOutput("first_addr", 32'(wr_addr), 32'h010);
         applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b1, !vecs[i].exp_legal);
         if (i == 0) checkOutput("first_count", 32'(count), 32'h1);
      end
      checkOutput("err_cleared", 32'(err), 32'h0);
      checkOutput("table_count", 32'(count), 32'd9);

      // Backpressure: five requests against a stalled memory.
      applyStimulus(1'b1, 10'h100, 1'b0, idle, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 10'h0, 1'b1, mkReq(6, 1, 2, 0, 0, i, 0), 1'b0, 1'b0);
      checkOutput("ready_full", 32'(req_ready), 32'h0);
      rr = mkReq(6, 1, 2, 0, 0, 4, 0);
      applyStimulus(1'b0, 10'h0, 1'b1, rr, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h0, 1'b1, rr, 1'b1, 1'b0);
      checkOutput("ready_after_pop", 32'(req_ready), 32'h1);
      applyStimulus(1'b0, 10'h0, 1'b1, rr, 1'b0, 1'b0);
      for (int k = 1; k < 5; k++) begin
         checkOutput("order", wr_data, 32'h1E088000 + 32'(k));
         applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b1, 1'b0);
      end
      checkOutput("drained", 32'(busy), 32'h0);

      // Address wrap at the top of instruction memory.
      applyStimulus(1'b1, 10'h3FF, 1'b0, idle, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h0, 1'b1, mkReq(3, 0, 0, 0, 0, 0, 'h10), 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h0, 1'b1, mkReq(3, 0, 0, 0, 0, 0, 'h20), 1'b0, 1'b0);
      checkOutput("wrap_addr0", 32'(wr_addr), 32'h3FF);
      checkOutput("wrap_data0", wr_data, 32'h1B000010);
      applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b1, 1'b0);
      checkOutput("wrap_addr1", 32'(wr_addr), 32'h000);
      checkOutput("wrap_data1", wr_data, 32'h1B000020);
      applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b1, 1'b0);

      // start colliding with a push and a write handshake.
      applyStimulus(1'b0, 10'h0, 1'b1, mkReq(3, 0, 0, 0, 0, 0, 'h1), 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h0, 1'b1, mkReq(3, 0, 0, 0, 0, 0, 'h2), 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h020, 1'b1, mkReq(3, 0, 0, 0, 0, 0, 'h3), 1'b1, 1'b0);
      checkOutput("start_data", wr_data, 32'h1B000003);
      checkOutput("start_addr", 32'(wr_addr), 32'h020);
      checkOutput("start_count", 32'(count), 32'h0);
      applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b1, 1'b0);

      // Asynchronous reset with three entries queued.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 10'h0, 1'b1, mkReq(6, 0, 0, 0, 0, i, 0), 1'b0, 1'b0);
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_wr_en", 32'(wr_en), 32'h0);
      checkOutput("rst_count", 32'(count), 32'h0);
      compareModel();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b1, 1'b0);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         int imm;
         int kind;
         kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
         imm  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 16383)) - 8192
                                            : int'($urandom_range(0, 65535));
         rr = mkReq(kind, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), imm,
                    int'($urandom_range(0, 24'hFFFFFF)));
         applyStimulus($urandom_range(0, 49) == 0, 10'($urandom_range(0, 1023)),
                       $urandom_range(0, 1) == 1, rr, $urandom_range(0, 9) < 7,
                       $urandom_range(0, 9) == 0);
      end
      applyStimulus(1'b0, 10'h0, 1'b0, idle, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader: the write-side counterpart of the control decoder. It accepts symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake. Each request is packed into a 32-bit instruction word whose opcode and funct fields match what the control decoder recognises. A 4-entry FIFO buffers the words, and they are streamed into instruction memory at consecutive word addresses from a programmable base. The block is used by the test/boot path to load programs into the single-cycle core's instruction memory.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 4, FIFO depth in entries (power of two, at least 2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: flush FIFO, load write address from base_addr, clear count
- base_addr  in  ADDR_W  first word address, sampled on start
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_kind  in  4  0 R, 1 LW, 2 SW, 3 J, 4 BEQ, 5 BNE, 6 ADDI, 7 JAL, 8 JR; 9–15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_funct  in  4  R-type funct
- req_imm  in  16  signed immediate
- req_target  in  24  jump target
- wr_en  out  1  instruction-memory write request
- wr_addr  out  ADDR_W  write word address
- wr_data  out  32  encoded instruction
- wr_ready  in  1  memory accepts the write this cycle
- busy  out  1  FIFO non-empty
- count  out  16  instructions written since start (saturates at 0xFFFF)
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation
- Instruction word formats:
  - Opcode is always [31:24].
  - R-type: rs [23:19], rt [18:14], rd [13:9], [8:4] = 0, funct [3:0].
  - I-type: rs [23:19], rt [18:14], imm [13:0].
  - J-type: target [23:0].
- Opcodes:
  - R = 0x18, LW = 0x19, SW = 0x1A, J = 0x1B, BEQ = 0x1C, BNE = 0x1D, ADDI = 0x1E, JAL = 0x03.
  - JR = opcode 0x00, rs = req_rs, funct = 4'b1000, all other fields 0.
- LW, SW, BEQ, BNE and ADDI are I-type. J and JAL are J-type.
- Immediate range: I-type requires req_imm in −8192..8191; the low 14 bits are stored.
- Handshake: a request is accepted when req_valid && req_ready. Once accepted, exactly one of the following happens:
  - legal: encoded and pushed into the FIFO;
  - illegal kind or out-of-range immediate: discarded, err set.
- Write port:
  - wr_en = FIFO non-empty; wr_data = head entry; wr_addr = address register.
  - On wr_en && wr_ready: pop the head, wr_addr += 1 (wraps modulo 2^ADDR_W), count += 1 (saturating).
- start:
  - FIFO cleared, address register ← base_addr, count ← 0. err is not affected.
  - A request accepted in the same cycle as start is enqueued into the emptied FIFO.
  - A write handshake in the start cycle is discarded (no pop or count effect beyond the flush).
- err set and err_clr in the same cycle: set wins.

## Timing
- Reset values: FIFO empty, wr_en 0, wr_addr 0, wr_data 0, count 0, err 0, busy 0, req_ready 1.
- Latency: a request accepted at edge N appears on wr_en/wr_data from cycle N+1.
- req_ready = occupancy < DEPTH. There is no full-bypass: when full, ready stays low even if a pop occurs in that cycle.
- Push and pop in the same cycle when non-empty and not full: occupancy unchanged, order preserved.
- wr_data and wr_addr hold stable while wr_en && !wr_ready.
- err rises one cycle after the offending handshake.
- rst_n asserted mid-stream: all state returns to reset values immediately; no partial write is issued after deassertion.

## Structure
- Shared package holds:
  - opcode constants (OP_R … OP_JAL, FUNCT_JR);
  - the req_kind encoding;
  - field bit positions;
  - IMM_MIN/IMM_MAX.
- Encoding is a combinational function in the top level.
- One sub-module: instr_fifo, a synchronous FIFO with parameters DEPTH and width 32, and ports push/pop/full/empty/head.

## Test plan
- After reset, start with base_addr = 0x010, then ADDI rs=1 rt=2 imm=5 → wr_en in the next cycle, wr_addr 0x010, wr_data 0x1E088005, count 1.
- LW rs=0 rt=3 imm=−4, then R rs=1 rt=2 rd=3 funct=2, then JR rs=31, with wr_ready=1 → writes 0x1900FFFC, 0x18088602, 0x00F80008 at consecutive addresses.
- Hold wr_ready=0 and push 5 requests → req_ready low after the 4th; the 5th is held until one pop; order is preserved.
- req_kind=12, then ADDI with imm=9000 → neither is written, err=1; err_clr → err=0.
- base_addr = 2^ADDR_W−1 with two J requests (targets 0x10, 0x20) → wr_addr wraps to 0; data 0x1B000010, 0x1B000020.
- Assert rst_n low while 3 entries are queued → wr_en 0, count 0 immediately; no write occurs after release.
